joy_db15_responder: RTL

//   Target-side model of a DB15 arcade-stick adapter: the 74HC165-style

---
 rtl/joy_db15_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/joy_db15_responder.sv
// Target-side model of a DB15 arcade-stick adapter's 74HC165 chain.
// The host polls JOY_LOAD/JOY_CLK asynchronously; two player words are serialised on JOY_DATA.
module joy_db15_responder #(
  parameter int CHAIN_LEN   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 480000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_LOAD,
  input  logic        JOY_CLK,
  output logic        JOY_DATA,
  output logic        link_active,
  output logic        frame_done,
  output logic        overrun,
  output logic [7:0]  frame_cnt
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc_bit(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [WD_W-1:0] sat_inc_wd(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + 1'b1;
  endfunction

  logic [1:0] rst_pipe;
  logic       rst_n_int;

  logic [SYNC_STAGES-1:0] load_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   load_d;
  logic                   clk_d;
  logic                   load_s;
  logic                   clk_s;
  logic                   load_fall;
  logic                   clk_rise;

  logic [1:0]           state, state_nxt;
  logic [CHAIN_LEN-1:0] shreg, shreg_nxt;
  logic [CHAIN_LEN-1:0] load_img;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 overrun_nxt;
  logic                 frame_done_nxt;
  logic [7:0]           frame_cnt_nxt;
  logic [31:0]          player_words;

  logic [WD_W-1:0] wd_cnt;

  // Reset: asserts asynchronously, releases on clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n_int = rst_pipe[1];

  // Stage 0: pin synchronisers and edge-detect delay flops
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      load_sync <= '1;
      clk_sync  <= '0;
      load_d    <= 1'b1;
      clk_d     <= 1'b0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], JOY_LOAD};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], JOY_CLK};
      load_d    <= load_sync[SYNC_STAGES-1];
      clk_d     <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign load_s    = load_sync[SYNC_STAGES-1];
  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign load_fall = load_d & ~load_s;
  assign clk_rise  = clk_s & ~clk_d;

  // shreg holds the wire-level (active-low) image so released bits and the fill are 1s
  assign player_words = {joystick2, joystick1};

  always_comb begin
    load_img = '1;
    for (int i = 0; i < CHAIN_LEN && i < 32; i++) begin
      load_img[i] = ~player_words[i];
    end
  end

  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    bit_cnt_nxt    = bit_cnt;
    overrun_nxt    = overrun;
    frame_done_nxt = 1'b0;
    frame_cnt_nxt  = frame_cnt;
    if (!load_s) begin
      // Load dominates everything, including a coincident shift edge
      state_nxt   = ST_LOAD;
      shreg_nxt   = load_img;
      bit_cnt_nxt = '0;
      overrun_nxt = 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            shreg_nxt   = {1'b1, shreg[CHAIN_LEN-1:1]};
            bit_cnt_nxt = sat_inc_bit(bit_cnt);
            if (bit_cnt_nxt == CNT_MAX) begin
              frame_done_nxt = 1'b1;
              frame_cnt_nxt  = frame_cnt + 8'd1;
              state_nxt      = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (clk_rise) begin
            shreg_nxt   = {1'b1, shreg[CHAIN_LEN-1:1]};
            overrun_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // Stage 1: frame state and shift register
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state      <= ST_IDLE;
      shreg      <= '1;
      bit_cnt    <= '0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      overrun    <= overrun_nxt;
      frame_done <= frame_done_nxt;
      frame_cnt  <= frame_cnt_nxt;
    end
  end

  assign JOY_DATA = shreg[0];

  // Link watchdog runs independently of the frame FSM
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wd_cnt      <= WD_MAX;
      link_active <= 1'b0;
    end else if (load_fall) begin
      wd_cnt      <= '0;
      link_active <= 1'b1;
    end else begin
      wd_cnt <= sat_inc_wd(wd_cnt);
      if (sat_inc_wd(wd_cnt) == WD_MAX) begin
        link_active <= 1'b0;
      end
    end
  end

endmodule
